// File: rtl/cla_pipe_clk_if.sv
// Operand/result handshake bundle for cla_pipe_clk.
// master: operand source + result consumer; slave: the adder pipeline.
interface cla_pipe_clk_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             co;
  logic             ovf;

  modport master (
    output in_valid, a, b, ci, sub, out_ready,
    input  in_ready, out_valid, s, co, ovf
  );

  modport slave (
    input  in_valid, a, b, ci, sub, out_ready,
    output in_ready, out_valid, s, co, ovf
  );
endinterface

// File: rtl/cla_pipe_clk.sv
// Pipelined carry-lookahead adder/subtractor, CHUNK bits per stage.
// Latency WIDTH/CHUNK cycles after the operand register; one op per cycle.
// Optional: define CLA_PIPE_SAT_EN to saturate the result on signed overflow.
module cla_pipe_clk #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input logic           clock,
  input logic           reset,
  cla_pipe_clk_if.slave bus
);
  localparam int unsigned STAGES = WIDTH / CHUNK;
  localparam int unsigned GROUPS = CHUNK / 4;
  localparam int unsigned RW     = CHUNK + 2;

  if (((WIDTH % CHUNK) != 0) || ((CHUNK % 4) != 0)) begin : g_param_err
    $error("cla_pipe_clk: WIDTH must be a multiple of CHUNK and CHUNK a multiple of 4");
  end

  // One chunk of 4-bit CLA groups; returns {carry_out, carry_into_msb, sum}.
  function automatic logic [RW-1:0] cla_chunk(
    input logic [CHUNK-1:0] op_a,
    input logic [CHUNK-1:0] op_b,
    input logic             cin
  );
    logic [CHUNK-1:0] g;
    logic [CHUNK-1:0] p;
    logic [CHUNK:0]   c;
    logic             gg;
    logic             pg;
    int unsigned      bs;
    g    = op_a & op_b;
    p    = op_a ^ op_b;
    c    = '0;
    c[0] = cin;
    for (int unsigned grp = 0; grp < GROUPS; grp++) begin
      bs       = grp * 4;
      c[bs+1]  = g[bs] | (p[bs] & c[bs]);
      c[bs+2]  = g[bs+1] | (p[bs+1] & g[bs]) | (p[bs+1] & p[bs] & c[bs]);
      c[bs+3]  = g[bs+2] | (p[bs+2] & g[bs+1]) | (p[bs+2] & p[bs+1] & g[bs])
               | (p[bs+2] & p[bs+1] & p[bs] & c[bs]);
      gg       = g[bs+3] | (p[bs+3] & g[bs+2]) | (p[bs+3] & p[bs+2] & g[bs+1])
               | (p[bs+3] & p[bs+2] & p[bs+1] & g[bs]);
      pg       = &p[bs +: 4];
      c[bs+4]  = gg | (pg & c[bs]);
    end
    return {c[CHUNK], c[CHUNK-1], p ^ c[CHUNK-1:0]};
  endfunction

  // Level k feeds stage k; operands skew forward, finished sum chunks ride along.
  logic [STAGES-1:0] r_v;
  logic [WIDTH-1:0]  r_a [STAGES];
  logic [WIDTH-1:0]  r_b [STAGES];
  logic [WIDTH-1:0]  r_s [STAGES];
  logic              r_c [STAGES];

  logic              r_out_valid;
  logic [WIDTH-1:0]  r_s_out;
  logic              r_co;
  logic              r_ovf;

  logic [RW-1:0]     w_res    [STAGES];
  logic [WIDTH-1:0]  w_s_next [STAGES];
  logic [WIDTH-1:0]  w_s_fin;
  logic              w_cout;
  logic              w_ovf;
  logic              w_stall;

  assign w_stall       = r_out_valid & ~bus.out_ready;
  assign bus.in_ready  = ~w_stall;
  assign bus.out_valid = r_out_valid;
  assign bus.s         = r_s_out;
  assign bus.co        = r_co;
  assign bus.ovf       = r_ovf;

  // Per-stage chunk add and merge into the partially built result.
  always_comb begin
    for (int unsigned k = 0; k < STAGES; k++) begin
      w_res[k]    = cla_chunk(r_a[k][k*CHUNK +: CHUNK], r_b[k][k*CHUNK +: CHUNK], r_c[k]);
      w_s_next[k] = r_s[k];
      w_s_next[k][k*CHUNK +: CHUNK] = w_res[k][CHUNK-1:0];
    end
    w_cout  = w_res[STAGES-1][CHUNK+1];
    w_ovf   = w_res[STAGES-1][CHUNK+1] ^ w_res[STAGES-1][CHUNK];
    w_s_fin = w_s_next[STAGES-1];
`ifdef CLA_PIPE_SAT_EN
    if (w_ovf) begin
      // Carry out set means both operands were negative: clamp to most negative.
      w_s_fin = w_cout ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  // Pipeline advance; everything freezes while the output is stalled.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_v <= '0;
      for (int unsigned k = 0; k < STAGES; k++) begin
        r_a[k] <= '0;
        r_b[k] <= '0;
        r_s[k] <= '0;
        r_c[k] <= 1'b0;
      end
      r_out_valid <= 1'b0;
      r_s_out     <= '0;
      r_co        <= 1'b0;
      r_ovf       <= 1'b0;
    end else if (!w_stall) begin
      r_v[0] <= bus.in_valid;
      r_a[0] <= bus.a;
      r_b[0] <= bus.b ^ {WIDTH{bus.sub}};
      r_c[0] <= bus.sub | bus.ci;
      r_s[0] <= '0;
      for (int unsigned k = 1; k < STAGES; k++) begin
        r_v[k] <= r_v[k-1];
        r_a[k] <= r_a[k-1];
        r_b[k] <= r_b[k-1];
        r_s[k] <= w_s_next[k-1];
        r_c[k] <= w_res[k-1][CHUNK+1];
      end
      r_out_valid <= r_v[STAGES-1];
      // Bubbles leave the visible result untouched.
      if (r_v[STAGES-1]) begin
        r_s_out <= w_s_fin;
        r_co    <= w_cout;
        r_ovf   <= w_ovf;
      end
    end
  end
endmodule

// File: tb/tb_cla_pipe_clk.sv
// Self-checking bench for cla_pipe_clk: directed cases plus randomized stream
// with random backpressure, checked against an arithmetic reference queue.
module tb_cla_pipe_clk;
  localparam int unsigned WIDTH  = 32;
  localparam int unsigned CHUNK  = 8;
  localparam int unsigned STAGES = WIDTH / CHUNK;

  logic clk;
  logic rst;
  logic fixed_rdy;
  logic rand_rdy;
  logic rnd_rdy;

  int n_cmp;
  int n_err;
  int cyc;

  cla_pipe_clk_if #(.WIDTH(WIDTH)) bus ();

  cla_pipe_clk #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  assign bus.out_ready = rand_rdy ? rnd_rdy : fixed_rdy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    #1;
    rnd_rdy = ($urandom_range(0, 3) != 0);
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference result packed as {ovf, co, s}, from plain integer arithmetic.
  function automatic logic [WIDTH+1:0] ref_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                               input logic ci, input logic sub);
    logic [WIDTH:0]   full;
    logic [WIDTH-1:0] sum;
    logic             ovf;
    longint           sa;
    longint           sb;
    longint           sr;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sub) begin
      full = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
      sr   = sa - sb;
    end else begin
      full = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(ci);
      sr   = sa + sb + longint'(ci);
    end
    sum = full[WIDTH-1:0];
    ovf = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
`ifdef CLA_PIPE_SAT_EN
    if (ovf) sum = (sr > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
`endif
    return {ovf, full[WIDTH], sum};
  endfunction

  logic [WIDTH+1:0] exp_q [$];
  logic [WIDTH-1:0] obs_s [$];
  int               obs_t [$];
  logic             prev_stall;
  logic [WIDTH+1:0] prev_out;

  // Scoreboard: record accepted operands, compare every delivered result.
  always @(negedge clk) begin
    logic [WIDTH+1:0] e;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check_eq("hold_valid", 64'(bus.out_valid), 64'd1);
        check_eq("hold_data", 64'({bus.ovf, bus.co, bus.s}), 64'(prev_out));
      end
      if (bus.out_valid && !bus.out_ready)
        check_eq("stall_in_ready", 64'(bus.in_ready), 64'd0);
      if (bus.out_valid && bus.out_ready) begin
        obs_s.push_back(bus.s);
        obs_t.push_back(cyc);
        if (exp_q.size() == 0) begin
          check_eq("spurious_out", 64'(bus.s), 64'hDEAD_0000_0000_0000);
        end else begin
          e = exp_q.pop_front();
          check_eq("s",   64'(bus.s),   64'(e[WIDTH-1:0]));
          check_eq("co",  64'(bus.co),  64'(e[WIDTH]));
          check_eq("ovf", 64'(bus.ovf), 64'(e[WIDTH+1]));
        end
      end
      if (bus.in_valid && bus.in_ready)
        exp_q.push_back(ref_op(bus.a, bus.b, bus.ci, bus.sub));
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_out   = {bus.ovf, bus.co, bus.s};
    end
  end

  // Present one operation and hold it until the pipeline takes it.
  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic ci, input logic sub);
    bit done;
    int n;
    bus.a = a; bus.b = b; bus.ci = ci; bus.sub = sub; bus.in_valid = 1'b1;
    done = 1'b0;
    n = 0;
    while (!done) begin
      @(negedge clk);
      done = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
      if (!done && n > 200) begin
        check_eq("send_timeout", 64'(n), 64'd0);
        done = 1'b1;
      end
    end
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    bus.in_valid = 1'b0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("drain_left", 64'(exp_q.size()), 64'd0);
    idle(2);
  endtask

  function automatic logic [WIDTH-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      default: return WIDTH'($urandom());
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0; n_err = 0; cyc = 0;
    rst = 1'b1; fixed_rdy = 1'b1; rand_rdy = 1'b0; rnd_rdy = 1'b1;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.ci = 1'b0; bus.sub = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check_eq("rst_in_ready",  64'(bus.in_ready),  64'd1);
    check_eq("rst_s",         64'(bus.s),         64'd0);
    check_eq("rst_co_ovf",    64'({bus.co, bus.ovf}), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Latency: result appears exactly STAGES edges after acceptance, for one cycle.
    send('0, '0, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    for (int i = 1; i <= STAGES + 1; i++) begin
      @(posedge clk);
      #1;
      check_eq($sformatf("lat_valid_%0d", i), 64'(bus.out_valid), 64'(i == STAGES));
    end
    drain();

    // Back-to-back stream.
    obs_s.delete(); obs_t.delete();
    send(32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0);
    send(32'h0000_FFFF, 32'hFFFF_0000, 1'b0, 1'b0);
    send(32'h135F_A562, 32'h3561_4642, 1'b0, 1'b0);
    send(32'h135F_A562, 32'h3561_4642, 1'b1, 1'b0);
    drain();
    check_eq("b2b_count", 64'(obs_s.size()), 64'd4);
    if (obs_s.size() >= 4) begin
      check_eq("b2b_s0", 64'(obs_s[0]), 64'hFFFF_FFFF);
      check_eq("b2b_s1", 64'(obs_s[1]), 64'hFFFF_FFFF);
      check_eq("b2b_s2", 64'(obs_s[2]), 64'h48C0_EBA4);
      check_eq("b2b_s3", 64'(obs_s[3]), 64'h48C0_EBA5);
      check_eq("b2b_spacing", 64'(obs_t[3] - obs_t[0]), 64'd3);
    end

    // Carry out, subtract, overflow.
    obs_s.delete(); obs_t.delete();
    send(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0);
    send(32'd5, 32'd7, 1'b1, 1'b1);
    send(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0);
    drain();
    check_eq("edge_count", 64'(obs_s.size()), 64'd3);
    if (obs_s.size() >= 3) begin
      check_eq("carry_wrap_s", 64'(obs_s[0]), 64'h0);
      check_eq("sub_s", 64'(obs_s[1]), 64'hFFFF_FFFE);
`ifdef CLA_PIPE_SAT_EN
      check_eq("ovf_s", 64'(obs_s[2]), 64'h7FFF_FFFF);
`else
      check_eq("ovf_s", 64'(obs_s[2]), 64'h8000_0000);
`endif
    end

    // Backpressure: three ops held behind a stalled consumer.
    obs_s.delete(); obs_t.delete();
    fixed_rdy = 1'b0;
    send(32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0);
    send(32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0);
    send(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
    idle(STAGES + 5);
    check_eq("bp_in_ready", 64'(bus.in_ready), 64'd0);
    check_eq("bp_out_valid", 64'(bus.out_valid), 64'd1);
    check_eq("bp_s", 64'(bus.s), 64'h3);
    fixed_rdy = 1'b1;
    drain();
    check_eq("bp_count", 64'(obs_s.size()), 64'd3);

    // Reset mid-stream discards in-flight work.
    obs_s.delete(); obs_t.delete();
    send(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0);
    send(32'h3333_3333, 32'h4444_4444, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_eq("mrst_out_valid", 64'(bus.out_valid), 64'd0);
    check_eq("mrst_in_ready",  64'(bus.in_ready),  64'd1);
    check_eq("mrst_s",         64'(bus.s),         64'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(STAGES + 8);
    check_eq("mrst_no_stale", 64'(obs_s.size()), 64'd0);

    // Randomized stream with random backpressure and input gaps.
    obs_s.delete(); obs_t.delete();
    rand_rdy = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0)
        idle(1);
      else
        send(pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    bus.in_valid = 1'b0;
    rand_rdy = 1'b0;
    fixed_rdy = 1'b1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/cla_pipe_clk.md
Name: cla_pipe_clk

Overview:
Parametrised, pipelined carry-lookahead adder/subtractor with registered operands and a valid/ready handshake. It generalises the fixed 32-bit registered adder to any width and pipeline depth, and adds subtract mode and a signed-overflow flag. It sits between register-file-style operand sources and a downstream consumer that may apply backpressure. It accepts one operation per cycle when not stalled.

Parameters:
WIDTH, 32, operand/result width in bits; must be a multiple of CHUNK.
CHUNK, 8, bits added per pipeline stage; must be a multiple of 4 (built from 4-bit CLA groups).
STAGES (localparam), WIDTH/CHUNK, pipeline depth and latency in cycles.

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
in_valid  in  1  operand set present
in_ready  out  1  block can accept operands this cycle
a  in  WIDTH  operand A
b  in  WIDTH  operand B
ci  in  1  carry-in (add mode only)
sub  in  1  0 = a+b+ci, 1 = a-b (a+~b+1, ci ignored)
out_valid  out  1  result present
out_ready  in  1  consumer accepts result
s  out  WIDTH  sum/difference
co  out  1  carry-out; in sub mode 1 = no borrow
ovf  out  1  signed two's-complement overflow

Behaviour:
- Reset (async, active-high): all valid bits clear; s=0, co=0, ovf=0, out_valid=0, in_ready=1. Pipeline data registers clear. Reset asserted mid-operation discards all in-flight operations; nothing emerges afterwards.
- Accept: a transfer occurs when in_valid && in_ready at a rising edge. b is inverted and the effective carry-in is forced to 1 when sub=1.
- Stage k (0..STAGES-1) adds bits [k*CHUNK +: CHUNK] with 4-bit CLA groups (generate/propagate, group lookahead) and the carry registered from stage k-1. Upper operand chunks are skewed forward through the registers; lower result chunks are delayed to align.
- Latency: result for an operation accepted at edge N is on s/co/ovf with out_valid=1 after edge N+STAGES. Throughput is 1 op/cycle.
- ovf = carry into MSB XOR carry out of MSB, computed in the last stage.
- Stall: stall = out_valid && !out_ready. When stalled, every pipeline register (data and valid) holds, and in_ready=0. in_ready = !stall (combinational). Bubbles do not collapse.
- Output hold: s/co/ovf remain stable while out_valid && !out_ready. When out_valid=0, the outputs hold their last value.
- Simultaneous output acceptance and input acceptance in the same cycle is legal and loses no data.
- Wrap-around: results are modulo 2^WIDTH; the carry is reported only on co.
- Elaboration: if WIDTH % CHUNK != 0 or CHUNK % 4 != 0, the block raises a $error.

Optional Feature:
CLA_PIPE_SAT_EN: when defined, the final stage saturates on ovf=1. A positive overflow gives s={0,{WIDTH-1{1}}} and a negative overflow gives s={1,{WIDTH-1{0}}}; ovf and co are still reported. When undefined, s wraps (modulo), with no extra logic or latency either way.

Test Plan:
- Reset, then a=0, b=0, ci=0 with out_ready=1 -> after 4 cycles s=0x00000000, co=0, ovf=0, out_valid pulses 1 cycle.
- Back-to-back stream over 4 cycles: (0xFFFFFFFF+0, ci=0); (0x0000FFFF+0xFFFF0000); (0x135FA562+0x35614642, ci=0); same with ci=1 -> s=0xFFFFFFFF, 0xFFFFFFFF, 0x48C0EBA4, 0x48C0EBA5 on consecutive cycles, all co=0.
- Carry/subtract: 0xFFFFFFFF+0 with ci=1 -> s=0, co=1. Then sub=1, a=5, b=7 -> s=0xFFFFFFFE, co=0, ovf=0.
- Overflow: 0x7FFFFFFF+0x00000001 -> s=0x80000000, ovf=1 (with CLA_PIPE_SAT_EN: s=0x7FFFFFFF, ovf=1).
- Backpressure: issue 3 ops, hold out_ready=0 for 5 cycles -> in_ready=0 and outputs stable while stalled. Release -> all 3 results in order, none lost or duplicated.
- Reset mid-stream: assert reset 2 cycles after issuing 2 ops -> out_valid=0 immediately and no stale result appears after reset deasserts.
